sys_timer: RTL
==============

// Module: sys_timer
// PURPOSE
//  Memory-mapped countdown timer on the CPU's data bus, behind the system bridge.
//  Consumes the CPU's m_data_addr/wdata/byteen stores; returns load data.
//  Its irq output drives one bit of the CPU HWInt[5:0] vector.
//  Two instances (Timer0/Timer1) give HWInt[0]/HWInt[1].
// PARAMETERS
//  CNT_W  32  width of PRESET/COUNT registers; reads zero-extend to 32 bits
//  PSC_W  16  width of PSC register and prescale counter (used only with SYS_TIMER_PRESCALE_EN)
// PORTS
//  clk     in   1      system clock, rising edge
//  reset   in   1      asynchronous, active-high; clears all state
//  addr    in   32     byte address; only addr[3:2] decoded (0 CTRL, 1 PRESET, 2 COUNT, 3 PSC)
//  we      in   1      bridge select + write strobe for this timer
//  byteen  in   4      byte lanes written; write takes effect iff we && byteen!=0
//  wdata   in   32     store data, already lane-aligned
//  rdata   out  32     combinational read of register at addr[3:2]
//  irq     out  1      irq_flag & CTRL.IM
// BEHAVIOUR
//  Regs: CTRL[3:0] = {IM[3], MODE[2:1], EN[0]}; CTRL[31:4] read 0.
//    PRESET: R/W. COUNT: read-only; writes ignored.
//  Writes: byte-merge, lane i updated iff byteen[i]; bits beyond CNT_W dropped.
//  Any effective write to CTRL or PRESET (same edge):
//    - state <= IDLE, irq_flag <= 0;
//    - overrides every FSM update of that cycle, incl. FSM's EN clear.
//  Reset (async, any time incl. mid-count): CTRL, PRESET, COUNT, irq_flag = 0;
//    state = IDLE; rdata follows regs; irq = 0.
//  FSM (one transition per edge, absent a CTRL/PRESET write):
//    IDLE: EN=1 -> LOAD; else stay.
//    LOAD: COUNT <= PRESET; -> CNT.
//    CNT:  EN=0 -> IDLE (COUNT holds).
//          COUNT>1 -> COUNT-1, stay.
//          COUNT<=1 -> COUNT <= 0, irq_flag <= 1, -> INT.
//    INT:  MODE==1 (auto-reload): irq_flag <= 0, -> LOAD.
//          else (MODE 0/2/3, one-shot): CTRL.EN <= 0, -> IDLE; irq_flag held until CTRL/PRESET write.
//  Latency: PRESET=N>=2, write CTRL.EN=1 at edge 0 -> irq_flag set at edge N+2.
//    N=0 or 1 -> edge 3.
//  Auto-reload: irq high exactly 1 cycle; period N+2 cycles.
//  COUNT never wraps below 0.
//  Clearing IM masks irq without clearing irq_flag.
// CONFIGURATION
//  SYS_TIMER_PRESCALE_EN defined:
//    - PSC reg (R/W, PSC_W bits) at addr[3:2]=3; prescale counter pc cleared in LOAD and on reset.
//    - In CNT, the COUNT/irq step above happens only on edges where pc==PSC; then pc <= 0.
//    - On other edges pc <= pc+1, COUNT holds; EN=0 still exits immediately.
//    - Latency becomes 2 + max(N,1)*(PSC+1).
//  Not defined: no PSC storage; addr 3 reads 0, writes ignored; behaves as PSC=0.
// TESTING
//  1. Reset, PRESET=5, CTRL=0x9 (IM=1, one-shot)
//     -> COUNT 5,4,3,2,1,0; irq rises 7 edges after CTRL write;
//     EN reads 0; irq held; CTRL write 0x0 drops irq next edge.
//  2. PRESET=3, CTRL=0xB (auto-reload)
//     -> irq 1-cycle pulse every 5 cycles, 4 consecutive pulses checked.
//  3. byteen=4'b0010, wdata=0x0000AB00 to PRESET=0x11223344 -> PRESET reads 0x1122AB44;
//     write to COUNT leaves it unchanged; byteen=0 with we=1 is no write.
//  4. Mid-count (COUNT=7) CTRL.EN cleared -> IDLE, COUNT stays 7;
//     async reset asserted between edges -> all regs 0, irq 0 immediately.
//  5. PRESET written on the same edge the FSM enters INT -> state IDLE, irq_flag 0, new PRESET kept.
//  6. SYS_TIMER_PRESCALE_EN, PSC=2, PRESET=4, IM=1 -> irq at edge 14; without macro, addr 0xC reads 0.

Source files
------------

// File: rtl/sys_timer.sv
// Memory-mapped countdown timer with one-shot / auto-reload modes and a masked interrupt.
// Optional prescaler enabled by defining SYS_TIMER_PRESCALE_EN.
module sys_timer #(
   parameter int unsigned CNT_W = 32,
   parameter int unsigned PSC_W = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] addr_i,
   input  logic        we_i,
   input  logic [3:0]  byteen_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o,
   output logic        irq_o
);

   typedef enum logic [1:0] {StIdle, StLoad, StCnt, StInt} state_e;

   state_e           state_q;
   logic [3:0]       ctrl_q;
   logic [CNT_W-1:0] preset_q;
   logic [CNT_W-1:0] count_q;
   logic             irq_flag_q;

   logic             wr_en;
   logic             ctrl_wr;
   logic             preset_wr;
   logic [3:0]       ctrl_d;
   logic [CNT_W-1:0] preset_d;
   logic             tick;

   logic unused_addr;
   assign unused_addr = ^{addr_i[31:4], addr_i[1:0]};

   assign wr_en     = we_i && (byteen_i != 4'b0000);
   assign ctrl_wr   = wr_en && (addr_i[3:2] == 2'd0);
   assign preset_wr = wr_en && (addr_i[3:2] == 2'd1);

   always_comb begin
      ctrl_d   = byteen_i[0] ? wdata_i[3:0] : ctrl_q;
      preset_d = preset_q;
      for (int b = 0; b < CNT_W; b++) begin
         if (byteen_i[b/8]) preset_d[b] = wdata_i[b];
      end
   end

`ifdef SYS_TIMER_PRESCALE_EN
   logic [PSC_W-1:0] psc_q;
   logic [PSC_W-1:0] psc_d;
   logic [PSC_W-1:0] pc_q;

   always_comb begin
      psc_d = psc_q;
      for (int b = 0; b < PSC_W; b++) begin
         if (byteen_i[b/8]) psc_d[b] = wdata_i[b];
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         psc_q <= '0;
      end else if (wr_en && (addr_i[3:2] == 2'd3)) begin
         psc_q <= psc_d;
      end
   end

   assign tick = (pc_q == psc_q);
`else
   logic [PSC_W-1:0] unused_psc;
   assign unused_psc = '0;
   assign tick       = 1'b1;
`endif

   // A CTRL/PRESET write restarts the timer and suppresses every FSM update on that edge.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= StIdle;
         ctrl_q     <= '0;
         preset_q   <= '0;
         count_q    <= '0;
         irq_flag_q <= 1'b0;
`ifdef SYS_TIMER_PRESCALE_EN
         pc_q       <= '0;
`endif
      end else if (ctrl_wr || preset_wr) begin
         state_q    <= StIdle;
         irq_flag_q <= 1'b0;
         if (ctrl_wr)   ctrl_q   <= ctrl_d;
         if (preset_wr) preset_q <= preset_d;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (ctrl_q[0]) state_q <= StLoad;
            end
            StLoad: begin
               count_q <= preset_q;
               state_q <= StCnt;
`ifdef SYS_TIMER_PRESCALE_EN
               pc_q    <= '0;
`endif
            end
            StCnt: begin
               if (!ctrl_q[0]) begin
                  state_q <= StIdle;
               end else if (tick) begin
                  if (count_q > CNT_W'(1)) begin
                     count_q <= count_q - CNT_W'(1);
                  end else begin
                     count_q    <= '0;
                     irq_flag_q <= 1'b1;
                     state_q    <= StInt;
                  end
               end
`ifdef SYS_TIMER_PRESCALE_EN
               if (ctrl_q[0]) pc_q <= tick ? '0 : pc_q + PSC_W'(1);
`endif
            end
            StInt: begin
               if (ctrl_q[2:1] == 2'd1) begin
                  irq_flag_q <= 1'b0;
                  state_q    <= StLoad;
               end else begin
                  ctrl_q[0] <= 1'b0;
                  state_q   <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   always_comb begin
      rdata_o = '0;
      case (addr_i[3:2])
         2'd0: rdata_o[3:0]       = ctrl_q;
         2'd1: rdata_o[CNT_W-1:0] = preset_q;
         2'd2: rdata_o[CNT_W-1:0] = count_q;
         default: begin
`ifdef SYS_TIMER_PRESCALE_EN
            rdata_o[PSC_W-1:0] = psc_q;
`endif
         end
      endcase
   end

   assign irq_o = irq_flag_q & ctrl_q[3];

endmodule
